// File: rtl/reset_sequencer.sv
// Staged reset release: all sub-block resets are held, then released one stage at a time once each reports ready.
// Optional ready-wait timeout is enabled by defining RESET_SEQ_TIMEOUT_EN.
module reset_sequencer #(
  parameter int STAGES      = 4,
  parameter int SYNC_DEPTH  = 2,
  parameter int STAGE_DELAY = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              soft_reset_req,
  input  logic [STAGES-1:0] stage_ready,
  output logic [STAGES-1:0] stage_reset,
  output logic              seq_done,
  output logic              timeout_err,
  output logic [2:0]        err_stage,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_ASSERT = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int          SW       = SYNC_DEPTH - 1;
  localparam logic [15:0] DLY      = 16'(STAGE_DELAY);
  localparam logic [15:0] DLY_M1   = 16'(STAGE_DELAY - 1);
  localparam logic [2:0]  LAST_IDX = 3'(STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int          TO_SUM   = STAGE_DELAY + TIMEOUT;
  localparam logic [15:0] TO_LIM   = (TO_SUM > 65535) ? 16'hFFFF : 16'(TO_SUM);
`endif

  // Handshake: stage i is released by clearing stage_reset[i]; its ready bit is
  // only sampled once STAGE_DELAY cycles have elapsed since that release, and
  // the next stage is released on the edge where both conditions hold.

  state_e             state_q, state_d;
  logic [SW-1:0]      sync_q;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [STAGES-1:0]  rst_q, rst_d;
  logic               done_q, done_d;
  logic               terr_q, terr_d;
  logic [2:0]         est_q, est_d;

  logic [7:0]         ready_ext;
  logic               ready_sel;
  logic               advance;
  logic               to_hit;
  logic [STAGES-1:0]  next_mask;

  // The state register's S_SYNC -> S_ASSERT transition acts as the final synchronizer flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SW'(1);
    end
  end

  assign ready_ext = 8'(stage_ready);
  assign ready_sel = ready_ext[idx_q];
  assign next_mask = STAGES'(1) << (idx_q + 3'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    terr_d  = terr_q;
    est_d   = est_q;
    advance = 1'b0;
    to_hit  = 1'b0;

    case (state_q)
      S_SYNC: begin
        rst_d = '1;
        cnt_d = '0;
        if (sync_q[SW-1]) state_d = S_ASSERT;
      end
      S_ASSERT: begin
        if (cnt_q == DLY_M1) begin
          rst_d   = ~(STAGES'(1));
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
`ifdef RESET_SEQ_TIMEOUT_EN
        to_hit = (cnt_q >= TO_LIM) && !ready_sel;
`endif
        advance = ((cnt_q >= DLY) && ready_sel) || to_hit;
        if (to_hit) begin
          terr_d = 1'b1;
          est_d  = idx_q;
        end
        if (advance) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            rst_d   = '0;
          end else begin
            rst_d = rst_q & ~next_mask;
            idx_d = idx_q + 3'd1;
            cnt_d = '0;
          end
        end
      end
      S_DONE: begin
        rst_d  = '0;
        done_d = 1'b1;
      end
      default: state_d = S_SYNC;
    endcase

    // A re-sequence request outranks any advance on the same edge.
    if (soft_reset_req && (state_q == S_WAIT || state_q == S_DONE)) begin
      state_d = S_ASSERT;
      cnt_d   = '0;
      idx_d   = 3'd0;
      rst_d   = '1;
      done_d  = 1'b0;
      terr_d  = 1'b0;
      est_d   = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      est_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      est_q   <= est_d;
    end
  end

  assign stage_reset = rst_q;
  assign seq_done    = done_q;
  assign timeout_err = terr_q;
  assign err_stage   = est_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: release timing, late ready, timeout, soft reset, collision and async abort.
module tb_reset_sequencer;
  localparam int STAGES = 4;
  localparam int W      = STAGES + 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              soft_reset_req = 1'b0;
  logic [STAGES-1:0] stage_ready = 4'hF;
  logic [STAGES-1:0] stage_reset;
  logic              seq_done;
  logic              timeout_err;
  logic [2:0]        err_stage;
  logic [1:0]        dbg_state;

  reset_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .soft_reset_req (soft_reset_req),
    .stage_ready    (stage_ready),
    .stage_reset    (stage_reset),
    .seq_done       (seq_done),
    .timeout_err    (timeout_err),
    .err_stage      (err_stage),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int         at_edge;
    logic [3:0] ready;
    logic [3:0] exp_rst;
    logic       exp_done;
  } vec_t;

  vec_t pwr[10];

  function automatic logic [W-1:0] pack(logic [3:0] r, logic d, logic te, logic [2:0] es);
    return {r, d, te, es};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_n(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_to(int e);
    while (edge_n < e) step();
  endtask

  task automatic compare(string name);
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected value queued", name);
      return;
    end
    exp_v = exp_q.pop_front();
    act_v = {stage_reset, seq_done, timeout_err, err_stage};
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got rst/done/terr/estage=%b required %b (edge %0d)", name, act_v, exp_v, edge_n);
    end
  endtask

  task automatic expect_now(string name, logic [W-1:0] e);
    exp_q.push_back(e);
    compare(name);
  endtask

  task automatic run_power_up(string tag);
    reset_n = 1'b0;
    step_n(5);
    expect_now({tag, "_in_reset"}, pack(4'hF, 1'b0, 1'b0, 3'd0));
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL %s_state: got %0d required 0", tag, dbg_state);
    end
    for (int i = 0; i < 10; i++) exp_q.push_back(pack(pwr[i].exp_rst, pwr[i].exp_done, 1'b0, 3'd0));
    reset_n = 1'b1;
    edge_n  = 0;
    for (int i = 0; i < 10; i++) begin
      stage_ready = pwr[i].ready;
      step_to(pwr[i].at_edge);
      compare($sformatf("%s_e%0d", tag, pwr[i].at_edge));
    end
  endtask

  task automatic pulse_soft();
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pwr[0] = '{17, 4'hF, 4'b1111, 1'b0};
    pwr[1] = '{18, 4'hF, 4'b1110, 1'b0};
    pwr[2] = '{34, 4'hF, 4'b1110, 1'b0};
    pwr[3] = '{35, 4'hF, 4'b1100, 1'b0};
    pwr[4] = '{51, 4'hF, 4'b1100, 1'b0};
    pwr[5] = '{52, 4'hF, 4'b1000, 1'b0};
    pwr[6] = '{68, 4'hF, 4'b1000, 1'b0};
    pwr[7] = '{69, 4'hF, 4'b0000, 1'b0};
    pwr[8] = '{85, 4'hF, 4'b0000, 1'b0};
    pwr[9] = '{86, 4'hF, 4'b0000, 1'b1};

    #1;
    run_power_up("pwr");

    // Soft reset 10 cycles after done; ready[2] held low for the late-ready case.
    step_n(10);
    stage_ready = 4'b1011;
    edge_n = 0;
    pulse_soft();
    expect_now("soft_reassert", pack(4'b1111, 1'b0, 1'b0, 3'd0));
    step_to(16);
    expect_now("soft_hold", pack(4'b1111, 1'b0, 1'b0, 3'd0));
    step_to(17);
    expect_now("soft_rel0", pack(4'b1110, 1'b0, 1'b0, 3'd0));
    step_to(51);
    expect_now("late_rel2", pack(4'b1000, 1'b0, 1'b0, 3'd0));
    step_to(151);
    expect_now("late_hold3", pack(4'b1000, 1'b0, 1'b0, 3'd0));
    stage_ready = 4'hF;
    step();
    expect_now("late_rel3", pack(4'b0000, 1'b0, 1'b0, 3'd0));
    step_to(168);
    expect_now("late_predone", pack(4'b0000, 1'b0, 1'b0, 3'd0));
    step();
    expect_now("late_done", pack(4'b0000, 1'b1, 1'b0, 3'd0));

    // Soft reset on the same edge stage_ready[0] qualifies.
    step_n(3);
    edge_n = 0;
    pulse_soft();
    step_to(33);
    expect_now("collide_pre", pack(4'b1110, 1'b0, 1'b0, 3'd0));
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    expect_now("collide", pack(4'b1111, 1'b0, 1'b0, 3'd0));
    step_to(39);
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    expect_now("assert_ignore", pack(4'b1111, 1'b0, 1'b0, 3'd0));
    step_to(50);
    expect_now("collide_rel0", pack(4'b1110, 1'b0, 1'b0, 3'd0));
    step_to(67);
    expect_now("abort_pre", pack(4'b1100, 1'b0, 1'b0, 3'd0));

    // Asynchronous abort between edges.
    step_n(3);
    #2;
    reset_n = 1'b0;
    #1;
    expect_now("abort_async", pack(4'b1111, 1'b0, 1'b0, 3'd0));
    run_power_up("restart");

    // Stage 1 never reports ready.
    stage_ready = 4'b1101;
    reset_n = 1'b0;
    step_n(3);
    reset_n = 1'b1;
    edge_n = 0;
    step_to(35);
    expect_now("to_rel1", pack(4'b1100, 1'b0, 1'b0, 3'd0));
`ifdef RESET_SEQ_TIMEOUT_EN
    step_to(306);
    expect_now("to_pre", pack(4'b1100, 1'b0, 1'b0, 3'd0));
    step();
    expect_now("to_rel2", pack(4'b1000, 1'b0, 1'b1, 3'd1));
    step_to(324);
    expect_now("to_rel3", pack(4'b0000, 1'b0, 1'b1, 3'd1));
    step_to(341);
    expect_now("to_done", pack(4'b0000, 1'b1, 1'b1, 3'd1));
`else
    step_to(400);
    expect_now("no_to_hold", pack(4'b1100, 1'b0, 1'b0, 3'd0));
`endif
    pulse_soft();
    expect_now("soft_clear_flags", pack(4'b1111, 1'b0, 1'b0, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the board-level power-on/system reset and releases the clock domain's sub-block resets one stage at a time, in a fixed order. Stage i+1 is released only after stage i reports ready. It sits directly downstream of the power-on reset generator and drives the resets of the Wi-Fi link, time-keeping and display blocks. It also provides a software-requested re-sequence path.

## Interface
- `STAGES`, 4: number of sequenced reset outputs (1–8).
- `SYNC_DEPTH`, 2: flops in the reset-deassertion synchronizer (≥2).
- `STAGE_DELAY`, 16: minimum cycles between a stage's release and sampling of its ready (1–255).
- `TIMEOUT`, 255: ready-wait window in cycles, used only with the timeout feature (1–65535).

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `soft_reset_req` in 1: one-cycle pulse requesting a full re-sequence.
- `stage_ready` in STAGES: bit i is high when stage i has finished its own initialisation.
- `stage_reset` out STAGES: active-high reset to stage i.
- `seq_done` out 1: high once all stages are released.
- `timeout_err` out 1: sticky flag; a stage was skipped on timeout.
- `err_stage` out 3: index of the most recent timed-out stage.

## Operation
- `reset_n` low forces the following immediately, independent of `clk`:
  - `stage_reset` = all ones, `seq_done` = 0, `timeout_err` = 0, `err_stage` = 0.
  - Synchronizer is cleared and state = S_SYNC.
- **S_SYNC:** after `reset_n` rises, a 1 propagates through the SYNC_DEPTH synchronizer; then go to S_ASSERT with the cycle counter cleared.
- **S_ASSERT:** all stages are held in reset for STAGE_DELAY cycles, then stage 0 is released and the FSM enters S_WAIT with idx = 0.
- **S_WAIT(idx):**
  - The counter increments every cycle from the release of stage idx.
  - Once the counter ≥ STAGE_DELAY and `stage_ready[idx]` = 1:
    - if idx < STAGES-1, release stage idx+1, idx++ and clear the counter;
    - otherwise, go to S_DONE.
- **S_DONE:** `seq_done` = 1 and all `stage_reset` bits = 0.
- **`soft_reset_req`** in S_WAIT or S_DONE:
  - On the next edge, all `stage_reset` bits reassert, `seq_done` clears and `timeout_err`/`err_stage` clear.
  - The FSM goes to S_ASSERT; the synchronizer is not re-run.
  - The request is ignored in S_SYNC and S_ASSERT.
- **Ordering:**
  - Released stages stay released until a reset or a soft reset; a ready bit dropping later has no effect.
  - Bits of `stage_ready` above idx are ignored.
- **Simultaneous events:** if `soft_reset_req` and a ready-advance occur on the same edge, the soft reset wins.
- **Counters:** 16-bit, saturating; never wrap.

## Timing
- All outputs are registered.
- `stage_reset` asserts asynchronously on `reset_n` and deasserts synchronously.
- Edges are counted from the first rising `clk` edge with `reset_n` high (edge 1):
  - stage 0 releases at edge SYNC_DEPTH+STAGE_DELAY;
  - with ready already high, each later stage releases STAGE_DELAY+1 edges after the previous one;
  - `seq_done` rises STAGE_DELAY+1 edges after the last release.
- Ready-to-release latency is one edge once the delay has expired.
- Soft reset: all resets reassert 1 edge after the pulse, and stage 0 releases STAGE_DELAY edges after that.
- `reset_n` asserted mid-sequence aborts immediately with no partial state retained.

## Configuration
- `RESET_SEQ_TIMEOUT_EN` defined:
  - In S_WAIT, if the counter reaches STAGE_DELAY+TIMEOUT without ready, the sequencer advances as if ready were high.
  - `timeout_err` is set (sticky) and `err_stage` = idx.
- `RESET_SEQ_TIMEOUT_EN` undefined:
  - S_WAIT waits for ready indefinitely.
  - `timeout_err` and `err_stage` are tied to 0.

## Test plan
All scenarios use defaults: STAGES=4, SYNC_DEPTH=2, STAGE_DELAY=16, TIMEOUT=255.
- **Power-up, all ready high:** `reset_n` low 5 cycles then high → `stage_reset` = 1111 during reset; bit 0 falls at edge 18, bit 1 at 35, bit 2 at 52, bit 3 at 69; `seq_done` rises at edge 86.
- **Late ready:** hold `stage_ready[2]` low until 100 cycles after stage 2 release → `stage_reset[3]` stays 1 until exactly one edge after ready rises; `timeout_err` = 0.
- **Timeout (macro defined):** hold `stage_ready[1]` at 0 → stage 2 releases at edge 35+16+255+1 = 307; `timeout_err` = 1 and `err_stage` = 1 from that edge; sequence completes. With the macro undefined, stage 2 never releases.
- **Soft reset:** pulse `soft_reset_req` 10 cycles after `seq_done` → 1111 on the next edge, `seq_done` = 0, flags cleared; stage 0 releases 16 edges later.
- **Mid-sequence abort:** drop `reset_n` between edges after stage 1 release → `stage_reset` = 1111 before the next `clk` edge; full sequence restarts from S_SYNC with the timing of the power-up scenario.
- **Soft reset colliding with advance:** pulse `soft_reset_req` on the same edge `stage_ready[0]` qualifies → stage 1 is not released; all resets reassert.
